shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shift sequencer for the ALU shift path. It performs logical-left, logical-right, arithmetic-right and rotate-right operations on a 32-bit operand by applying a narrow shift stage repeatedly, STEP bits per cycle, under a start/busy/done handshake. It sits beside the combinational ALU, so the CPU control unit can use it for variable shifts (shift amount from a register) and stall on busy.

## Interface
- STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- data  in  32  operand to shift, captured with start.
- shamt  in  5  shift amount 0..31, captured with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; res is valid in that cycle.
- res  out  32  shifted result register.

## Operation
- States are IDLE, SHIFT and DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE with start=1:
  - Capture data into the working register, op into op_r, and shamt into count.
  - If shamt == 0, go to DONE and set res = data.
  - Otherwise go to SHIFT.
- IDLE with start=0: hold all state. res keeps its last value.
- SHIFT, each cycle: n = min(STEP, count).
  - Apply an n-bit shift to the working register according to op_r, then set count = count - n.
  - If the old count <= STEP, go to DONE and load res with the final shifted value.
  - Otherwise stay in SHIFT.
- Shift rules per step:
  - SLL fills with 0 from the LSB side.
  - SRL fills with 0 from the MSB side.
  - SRA fills with the current bit 31, which equals the original sign.
  - ROR moves the bits shifted out at the LSB back into the MSBs.
- DONE: lasts one cycle, then IDLE unconditionally. A start in DONE is ignored.
- start in SHIFT or DONE is ignored and not queued. data, op and shamt may change freely after capture.
- res holds its value from DONE until the next completion or reset.
- rst=1 in any state, including mid-operation, has the following effect on the next edge:
  - state = IDLE, count = 0, working register = 0, res = 0.
  - busy = 0 and done = 0.
  - Any in-flight operation is discarded with no done pulse.
- Reset values: busy 0, done 0, res 32'h0.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- k = ceil(shamt/STEP). SHIFT occupies cycles 1..k. done=1 and res is valid in cycle k+1.
- With STEP=1 and shamt=0, done is in cycle 1. With STEP=1 and shamt=31, done is in cycle 32.
- With STEP=4 and shamt=7, k=2 (steps of 4 then 3) and done is in cycle 3.
- busy is high in cycles 1..k+1 and low in cycle k+2.
- The earliest accepted back-to-back start is in cycle k+2, because start in the DONE cycle is ignored.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- STEP=1, op=01, data=32'h80000000, shamt=31 -> busy in cycles 1..32, done in cycle 32, res=32'h00000001.
- STEP=1, op=10, data=32'h80000000, shamt=4 -> done in cycle 5, res=32'hF8000000. Then op=10, data=32'h7FFFFFF0, shamt=4 -> res=32'h07FFFFFF.
- STEP=1, op=00, data=32'h00000001, shamt=0 -> done in cycle 1, res=32'h00000001. Then shamt=31 -> res=32'h80000000 in cycle 32.
- STEP=4, op=11, data=32'h12345678, shamt=8 -> done in cycle 3, res=32'h78123456. Then shamt=7, op=01, data=32'hFFFFFFFF -> done in cycle 3, res=32'h01FFFFFF.
- Start while busy: launch SRL of 32'hF0000000 by 4, pulse start with other operands in cycles 2 and 5 (the DONE cycle) -> single done in cycle 5, res=32'h0F000000, no second done.
- Reset mid-op: launch shamt=20 with STEP=1, assert rst in cycle 10 -> cycle 11 shows busy=0, done=0, res=0, and no done ever appears. A new start in cycle 12 completes normally.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle shift sequencer for the ALU shift path.
// SLL/SRL/SRA/ROR on 32 bits, STEP bits per cycle, start/busy/done handshake.
module shift_seq #(
  parameter int STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state;
  logic [1:0]  op_r;
  logic [5:0]  count;
  logic [31:0] work;
  logic [31:0] shifted;
  logic [5:0]  n;

  // one narrow shift of the working register by min(STEP, count)
  always_comb begin
    n       = (count < STEP_W) ? count : STEP_W;
    shifted = work;
    unique case (op_r)
      2'b00: shifted = work << n;
      2'b01: shifted = work >> n;
      2'b10: shifted = $signed(work) >>> n;
      2'b11: shifted = (work >> n) | (work << (6'd32 - n));
    endcase
  end

  // sequencer FSM with registered busy/done/res
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= 2'b00;
      count <= 6'd0;
      work  <= 32'h0;
      res   <= 32'h0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= data;
            op_r  <= op;
            count <= {1'b0, shamt};
            busy  <= 1'b1;
            if (shamt == 5'd0) begin
              state <= DONE;
              res   <= data;
              done  <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= shifted;
          count <= count - n;
          if (count <= STEP_W) begin
            state <= DONE;
            res   <= shifted;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: scoreboard bench for shift_seq.
// Two instances (STEP=1 and STEP=4) share stimulus; each has its own queue.
module tb_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;

  always #5 clk = ~clk;

  shift_seq #(.STEP(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data(data), .shamt(shamt),
    .busy(busy1), .done(done1), .res(res1)
  );

  shift_seq #(.STEP(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .data(data), .shamt(shamt),
    .busy(busy4), .done(done4), .res(res4)
  );

  typedef struct {
    logic [31:0] r;
    int          c;
  } exp_t;

  exp_t        q[2][$];
  int          acc[2];
  int          free[2];
  logic [31:0] last[2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int stp(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // full shift in one go, straight from the operation definitions
  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] d, int s);
    logic [63:0] t;
    case (o)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return $signed(d) >>> s;
      default: begin
        t = {d, d} >> s;
        return t[31:0];
      end
    endcase
  endfunction

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, stp(d), cyc, act, exp);
    end
  endtask

  task automatic mon(int d, logic b, logic dn, logic [31:0] r);
    exp_t e;
    chk("busy", d, {31'b0, b}, {31'b0, (acc[d] < cyc && cyc < free[d])});
    if (dn) begin
      if (q[d].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut%0d cyc %0d: got done=1 expected 0", stp(d), cyc);
      end else begin
        e = q[d].pop_front();
        chk("res", d, r, e.r);
        chk("done_cycle", d, 32'(cyc), 32'(e.c));
        last[d] = e.r;
      end
    end else begin
      chk("res_hold", d, r, last[d]);
      if (q[d].size() > 0 && q[d][0].c <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done dut%0d cyc %0d: got done=0 expected 1", stp(d), cyc);
        void'(q[d].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, busy1, done1, res1);
      mon(1, busy4, done4, res4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive start for one cycle; model decides which instance accepts it
  task automatic issue(logic [1:0] o, logic [31:0] d, logic [4:0] s);
    exp_t e;
    int k;
    start = 1'b1;
    op    = o;
    data  = d;
    shamt = s;
    for (int i = 0; i < 2; i++) begin
      if (cyc >= free[i]) begin
        k      = (int'(s) + stp(i) - 1) / stp(i);
        e.r    = ref_shift(o, d, int'(s));
        e.c    = cyc + k + 1;
        q[i].push_back(e);
        acc[i]  = cyc;
        free[i] = cyc + k + 2;
      end
    end
    step();
    start = 1'b0;
    op    = 2'($urandom);
    data  = $urandom;
    shamt = 5'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      if (free[i] > cyc) free[i] = cyc;
      last[i] = 32'h0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((cyc < free[0] || cyc < free[1]) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout cyc %0d: got busy expected idle", cyc);
    end
  endtask

  initial begin
    int c0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    data  = 32'h0;
    shamt = 5'd0;
    for (int i = 0; i < 2; i++) begin
      acc[i]  = -10;
      free[i] = 0;
      last[i] = 32'h0;
    end
    repeat (3) step();
    rst = 1'b0;
    chk("reset_res", 0, res1, 32'h0);
    chk("reset_res", 1, res4, 32'h0);
    chk("reset_busy_done", 0, {30'b0, busy1, done1}, 32'h0);
    chk("reset_busy_done", 1, {30'b0, busy4, done4}, 32'h0);
    mon_en = 1'b1;
    step();

    issue(2'b01, 32'h80000000, 5'd31); wait_idle();
    issue(2'b10, 32'h80000000, 5'd4);  wait_idle();
    issue(2'b10, 32'h7FFFFFF0, 5'd4);  wait_idle();
    issue(2'b00, 32'h00000001, 5'd0);  wait_idle();
    issue(2'b00, 32'h00000001, 5'd31); wait_idle();
    issue(2'b11, 32'h12345678, 5'd8);  wait_idle();
    issue(2'b01, 32'hFFFFFFFF, 5'd7);  wait_idle();

    // starts during busy and during the DONE cycle
    issue(2'b01, 32'hF0000000, 5'd4);
    step();
    issue(2'b00, 32'hDEADBEEF, 5'd3);
    step();
    step();
    issue(2'b11, 32'hCAFEF00D, 5'd9);
    wait_idle();

    // reset in the middle of an operation
    c0 = cyc;
    issue(2'($urandom), $urandom, 5'd20);
    while (cyc < c0 + 10) step();
    do_reset();
    chk("rst_mid_res", 0, res1, 32'h0);
    chk("rst_mid_flags", 0, {30'b0, busy1, done1}, 32'h0);
    step();
    issue(2'b10, 32'h80000001, 5'd5);
    wait_idle();

    for (int it = 0; it < 150; it++) begin
      logic [4:0] s;
      s = 5'($urandom);
      if (it % 10 == 0) s = 5'd0;
      if (it % 10 == 1) s = 5'd31;
      issue(2'($urandom), $urandom, s);
      repeat ($urandom_range(0, 36)) step();
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    wait_idle();
    repeat (3) step();
    chk("queue_empty", 0, 32'(q[0].size()), 32'h0);
    chk("queue_empty", 1, 32'(q[1].size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
